// File: rtl/ibuf_fetch_master.sv
// Port-A read initiator for the instruction buffer: burst commands in, credit-limited reads out, return FIFO to decode.
// Optional IBF_FETCH_PERF_EN adds stall/credit-starvation cycle counters.
module ibuf_fetch_master #(
    parameter int AW         = 15,
    parameter int DW         = 128,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WORDS  = 24576
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cmd_done,
    output logic             cmd_err,
    output logic             cen_a,
    output logic             wen_a,
    output logic             last_a,
    output logic [AW-1:0]    addr_a,
    output logic [DW-1:0]    wdata_a,
    output logic [DW/8-1:0]  wstrb_a,
    input  logic             ready_a,
    input  logic [DW-1:0]    rdata_a,
    input  logic             rvalid_a,
    input  logic             rlast_a,
    output logic             rready_a,
    output logic             ins_valid,
    output logic [DW-1:0]    ins_data,
    output logic             ins_last,
    input  logic             ins_ready
`ifdef IBF_FETCH_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_credit_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     addr_nxt;
    logic [LEN_W-1:0]  rem, rem_nxt;
    logic              done_nxt, err_nxt;
    logic [CW-1:0]     outstanding;
    logic              credit_ok, issue, push, pop, cmd_acc, full, empty;
    logic [PW:0]       wr_ptr, rd_ptr;
    logic [DW:0]       mem [FIFO_DEPTH];

    assign wen_a   = 1'b0;
    assign wdata_a = '0;
    assign wstrb_a = '0;

    assign credit_ok = outstanding < CW'(FIFO_DEPTH);
    assign issue     = cen_a && ready_a;
    assign push      = rvalid_a && rready_a;
    assign pop       = ins_valid && ins_ready;
    assign cmd_acc   = cmd_valid && cmd_ready;

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_a;
        rem_nxt   = rem;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        cmd_ready = 1'b0;
        cen_a     = 1'b0;
        last_a    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_addr >= AW'(MAX_WORDS)) begin
                        done_nxt = 1'b1;
                        err_nxt  = 1'b1;
                    end else begin
                        addr_nxt  = cmd_addr;
                        rem_nxt   = cmd_len;
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cen_a  = credit_ok;
                last_a = (rem == '0);
                if (credit_ok && ready_a) begin
                    addr_nxt = (addr_a == AW'(MAX_WORDS - 1)) ? '0 : addr_a + AW'(1);
                    if (rem == '0) state_nxt = DRAIN;
                    else           rem_nxt   = rem - LEN_W'(1);
                end
            end
            DRAIN: begin
                if (push && rlast_a) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_a   <= '0;
            rem      <= '0;
            cmd_done <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr_a   <= addr_nxt;
            rem      <= rem_nxt;
            cmd_done <= done_nxt;
            cmd_err  <= err_nxt;
        end
    end

    // Credit covers every beat from issue until it leaves the FIFO, so returns can never overflow it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({issue, pop})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign rready_a  = !full;
    assign ins_valid = !empty;
    assign {ins_last, ins_data} = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= {rlast_a, rdata_a};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

`ifdef IBF_FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt  <= '0;
            perf_credit_cnt <= '0;
        end else if (cmd_acc) begin
            perf_stall_cnt  <= '0;
            perf_credit_cnt <= '0;
        end else if (state == ISSUE) begin
            if (cen_a && !ready_a && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (!cen_a && perf_credit_cnt != '1)
                perf_credit_cnt <= perf_credit_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ibuf_fetch_master.sv
// Self-checking bench for ibuf_fetch_master: buffer-port model, address/data scoreboard, burst table plus corner sequences.
module tb_ibuf_fetch_master;

    localparam int AW = 15, DW = 128, LEN_W = 8, FD = 4, MW = 24576;

    logic             clk, rst_n;
    logic             cmd_valid, cmd_ready, cmd_done, cmd_err;
    logic [AW-1:0]    cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             cen_a, wen_a, last_a, ready_a, rvalid_a, rlast_a, rready_a;
    logic [AW-1:0]    addr_a;
    logic [DW-1:0]    wdata_a, rdata_a, ins_data;
    logic [DW/8-1:0]  wstrb_a;
    logic             ins_valid, ins_last, ins_ready;

    ibuf_fetch_master #(.AW(AW), .DW(DW), .LEN_W(LEN_W), .FIFO_DEPTH(FD), .MAX_WORDS(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_done(cmd_done), .cmd_err(cmd_err),
        .cen_a(cen_a), .wen_a(wen_a), .last_a(last_a), .addr_a(addr_a),
        .wdata_a(wdata_a), .wstrb_a(wstrb_a), .ready_a(ready_a),
        .rdata_a(rdata_a), .rvalid_a(rvalid_a), .rlast_a(rlast_a), .rready_a(rready_a),
        .ins_valid(ins_valid), .ins_data(ins_data), .ins_last(ins_last), .ins_ready(ins_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        return {8{1'b1, a}};
    endfunction

    typedef struct {
        logic [AW-1:0] a;
        logic          l;
        int            due;
    } ret_t;

    logic [AW:0]   exp_q[$];
    logic [DW:0]   sb_q[$];
    ret_t          ret_q[$];
    int            cyc = 0, rmode = 0, imode = 0;
    int            issued = 0, beats = 0, dones = 0, errs = 0;
    logic          prev_stall = 1'b0, prev_last = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    // Buffer port model and monitor: inputs change on the falling edge, handshakes sampled 1 time unit later.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            sb_q.delete();
            ret_q.delete();
            prev_stall = 1'b0;
            ready_a    = 1'b0;
            ins_ready  = 1'b0;
            rvalid_a   = 1'b0;
            rlast_a    = 1'b0;
            rdata_a    = '0;
        end else begin
            case (rmode)
                0:       ready_a = 1'b1;
                1:       ready_a = cyc[0];
                default: ready_a = 1'($urandom_range(0, 1));
            endcase
            case (imode)
                0:       ins_ready = 1'b1;
                1:       ins_ready = 1'b0;
                default: ins_ready = 1'($urandom_range(0, 1));
            endcase
            if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
                rvalid_a = 1'b1;
                rdata_a  = data_of(ret_q[0].a);
                rlast_a  = ret_q[0].l;
            end else begin
                rvalid_a = 1'b0;
                rdata_a  = '0;
                rlast_a  = 1'b0;
            end
            #1;
            if (prev_stall) begin
                chk("hold_cen", longint'(cen_a), 1);
                chk("hold_addr", longint'(addr_a), longint'(prev_addr));
                chk("hold_last", longint'(last_a), longint'(prev_last));
            end
            prev_stall = cen_a && !ready_a;
            prev_addr  = addr_a;
            prev_last  = last_a;
            if (cmd_valid && cmd_ready && int'(cmd_addr) < MW)
                for (int i = 0; i <= int'(cmd_len); i++)
                    exp_q.push_back({1'(i == int'(cmd_len)), AW'((int'(cmd_addr) + i) % MW)});
            if (cen_a && ready_a) begin
                logic [AW:0] e;
                issued++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", longint'(addr_a), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_addr", longint'(addr_a), longint'(e[AW-1:0]));
                    chk("issue_last", longint'(last_a), longint'(e[AW]));
                    sb_q.push_back({e[AW], data_of(e[AW-1:0])});
                end
                ret_q.push_back('{a: addr_a, l: last_a, due: cyc + 2});
            end
            if (rvalid_a && rready_a) void'(ret_q.pop_front());
            if (ins_valid && ins_ready) begin
                logic [DW:0] s;
                beats++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_ins", longint'(ins_last), -1);
                end else begin
                    s = sb_q.pop_front();
                    chk_data("ins_data", ins_data, s[DW-1:0]);
                    chk("ins_last", longint'(ins_last), longint'(s[DW]));
                end
            end
            if (cmd_done) dones++;
            if (cmd_err)  errs++;
        end
    end

    task automatic send_cmd(input logic [AW-1:0] a, input logic [LEN_W-1:0] l, input int rm, input int im);
        @(negedge clk);
        rmode     = rm;
        imode     = im;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(input string tag, input int d0, input int e0, input int i0, input int b0,
                              input int exp_err, input int exp_beats, input int lat_max);
        int n;
        n = 0;
        while (dones == d0 && n < 3000) begin
            @(negedge clk); #2; n++;
        end
        chk({tag, "_done_seen"}, longint'(n < 3000), 1);
        if (lat_max > 0) chk({tag, "_latency_ok"}, longint'(n <= lat_max), 1);
        n = 0;
        while ((sb_q.size() > 0 || ins_valid) && n < 3000) begin
            @(negedge clk); #2; n++;
        end
        repeat (3) @(negedge clk);
        #2;
        chk({tag, "_done_cnt"}, dones - d0, 1);
        chk({tag, "_err_cnt"}, errs - e0, exp_err);
        chk({tag, "_issued"}, issued - i0, exp_beats);
        chk({tag, "_beats"}, beats - b0, exp_beats);
        chk({tag, "_exp_left"}, exp_q.size(), 0);
        chk({tag, "_cmd_ready"}, longint'(cmd_ready), 1);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_cmd_ready"}, longint'(cmd_ready), 1);
        chk({tag, "_cen_a"}, longint'(cen_a), 0);
        chk({tag, "_last_a"}, longint'(last_a), 0);
        chk({tag, "_addr_a"}, longint'(addr_a), 0);
        chk({tag, "_cmd_done"}, longint'(cmd_done), 0);
        chk({tag, "_cmd_err"}, longint'(cmd_err), 0);
        chk({tag, "_ins_valid"}, longint'(ins_valid), 0);
        chk({tag, "_rready_a"}, longint'(rready_a), 1);
        chk({tag, "_wen_a"}, longint'(wen_a), 0);
    endtask

    typedef struct {
        logic [AW-1:0]    addr;
        logic [LEN_W-1:0] len;
        int               rm;
        int               im;
        int               exp_err;
        int               exp_beats;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0, i0, b0, n;
        tbl[0] = '{15'h0010,   3, 0, 0, 0,   4};
        tbl[1] = '{15'h5FFE,   3, 0, 0, 0,   4};
        tbl[2] = '{15'h0040,   7, 1, 0, 0,   8};
        tbl[3] = '{15'h6000,   0, 0, 0, 1,   0};
        tbl[4] = '{15'h7FFF,   5, 0, 0, 1,   0};
        tbl[5] = '{15'h0000,   0, 0, 0, 0,   1};
        tbl[6] = '{15'h1234,  31, 2, 2, 0,  32};
        tbl[7] = '{15'h5FF0, 255, 0, 0, 0, 256};
        tbl[8] = '{15'h5FFF,   0, 2, 0, 0,   1};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        ready_a = 1'b0; ins_ready = 1'b0; rvalid_a = 1'b0; rlast_a = 1'b0; rdata_a = '0;
        repeat (3) @(negedge clk);
        #2;
        reset_checks("rst_init");
        #1 rst_n = 1'b1;

        for (int k = 0; k < 9; k++) begin
            d0 = dones; e0 = errs; i0 = issued; b0 = beats;
            send_cmd(tbl[k].addr, tbl[k].len, tbl[k].rm, tbl[k].im);
            finish_cmd($sformatf("vec%0d", k), d0, e0, i0, b0, tbl[k].exp_err, tbl[k].exp_beats,
                       (tbl[k].rm == 0 && tbl[k].im == 0) ? int'(tbl[k].len) + 6 : 0);
        end

        // Consumer stalled: only FIFO_DEPTH requests may go out until pops free credit.
        d0 = dones; e0 = errs; i0 = issued; b0 = beats;
        send_cmd(15'h0100, 8'd15, 0, 1);
        repeat (20) @(negedge clk);
        #2;
        chk("credit_issued", issued - i0, FD);
        chk("credit_cen_low", longint'(cen_a), 0);
        chk("credit_ins_valid", longint'(ins_valid), 1);
        chk("credit_rready_low", longint'(rready_a), 0);
        imode = 0;
        finish_cmd("credit", d0, e0, i0, b0, 0, 16, 0);

        // Asynchronous reset in the middle of an 8-beat burst.
        i0 = issued;
        send_cmd(15'h0200, 8'd7, 0, 0);
        n = 0;
        while (issued - i0 < 2 && n < 50) begin
            @(negedge clk); #2; n++;
        end
        chk("midrst_reached_beat2", longint'(n < 50), 1);
        #1 rst_n = 1'b0;
        #1;
        reset_checks("rst_mid");
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;

        d0 = dones; e0 = errs; i0 = issued; b0 = beats;
        send_cmd(15'h0020, 8'd5, 0, 0);
        finish_cmd("post_rst", d0, e0, i0, b0, 0, 6, 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
